// File: rtl/mul_reduce_p25519.sv
// Karatsuba back end: recombines H0/L0/M0 into the 510-bit product and reduces it
// mod p = 2^255 - 19 to a canonical residue, tracking the multiplier latency with a valid pipe.
module mul_reduce_p25519 #(
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [253:0] H0,
  input  logic [255:0] L0,
  input  logic [257:0] M0,
  output logic         out_valid,
  output logic [254:0] Z,
  output logic         busy
);

  localparam int VP_LEN = MUL_LAT + 3;
  localparam logic [254:0] P_MOD = {255{1'b1}} - 255'd18;

  logic [VP_LEN-1:0] vp;
  logic              s1_en;
  logic              s2_en;
  logic              s3_en;

  logic [257:0] mid;
  logic [509:0] p_next;
  logic [509:0] p_q;

  logic [260:0] hi_ext;
  logic [260:0] t_next;
  logic [260:0] t_q;

  logic [255:0] carry_ext;
  logic [255:0] u;
  logic         u_ge_p;
  logic [254:0] z_next;

  // Partial products are valid in the cycle valid-pipe bit MUL_LAT-1 is set.
  assign s1_en = vp[MUL_LAT-1];
  assign s2_en = vp[MUL_LAT];
  assign s3_en = vp[MUL_LAT+1];

  assign out_valid = vp[VP_LEN-1];
  assign busy      = |vp;

  // Karatsuba middle term: A1*B2 + A2*B1, non-negative, top bit always zero.
  always_comb begin
    mid    = M0 - {4'b0, H0} - {2'b0, L0};
    p_next = {H0, 256'b0} + ({252'b0, mid} << 128) + {254'b0, L0};
  end

  // 2^256 == 38 mod p; 38*x built as (x<<5)+(x<<2)+(x<<1).
  always_comb begin
    hi_ext = {7'b0, p_q[509:256]};
    t_next = {5'b0, p_q[255:0]} + (hi_ext << 5) + (hi_ext << 2) + (hi_ext << 1);
  end

  // 2^255 == 19 mod p; U < 2p so one conditional subtraction canonicalizes.
  // When u[255] is set, subtracting p modulo 2^255 yields the small true result.
  always_comb begin
    carry_ext = {250'b0, t_q[260:255]};
    u         = {1'b0, t_q[254:0]} + (carry_ext << 4) + (carry_ext << 1) + carry_ext;
    u_ge_p    = u[255] | (u[254:0] >= P_MOD);
    z_next    = u_ge_p ? (u[254:0] - P_MOD) : u[254:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vp  <= '0;
      p_q <= '0;
      t_q <= '0;
      Z   <= '0;
    end else begin
      vp <= {vp[VP_LEN-2:0], in_valid};
      if (s1_en) p_q <= p_next;
      if (s2_en) t_q <= t_next;
      if (s3_en) Z   <= z_next;
    end
  end

endmodule
